// File: rtl/uart_alu_sequencer.sv
// Collects operand A, operand B and opcode bytes from rx, lets the ALU settle for one
// cycle, then hands the result to tx and waits for it to finish.
module uart_alu_sequencer #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  localparam int unsigned NbCnt = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NbCnt-1:0] CntMax = NbCnt'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitB,
    StWaitOp,
    StExec,
    StSend,
    StWaitDone
  } state_e;

  state_e             state_q, state_d;
  logic [NbCnt-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tx_data_d = tx_data_q;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_rx_valid) begin
          alu_a_d = i_rx_data;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        // An arriving byte beats a simultaneous expiry.
        if (i_rx_valid) begin
          alu_b_d = i_rx_data;
          state_d = StWaitOp;
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitOp: begin
        if (i_rx_valid) begin
          alu_op_d = i_rx_data[NB_OP-1:0];
          state_d  = StExec;
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec: begin
        tx_data_d = i_alu_result;
        overrun_d = i_rx_valid;
        state_d   = StSend;
      end
      StSend: begin
        overrun_d = i_rx_valid;
        state_d   = StWaitDone;
      end
      StWaitDone: begin
        overrun_d = i_rx_valid;
        if (i_tx_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      tx_data_q <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      tx_data_q <= tx_data_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = (state_q == StSend);
  assign o_busy     = (state_q != StIdle);
  assign o_timeout  = timeout_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer with a small timeout and an adder ALU model.
module tb_uart_alu_sequencer;

  localparam int unsigned NbData  = 8;
  localparam int unsigned NbOp    = 6;
  localparam int unsigned Timeout = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NbData-1:0] rx_data = '0;
  logic              rx_valid = 1'b0;
  logic [NbData-1:0] alu_result;
  logic              tx_done = 1'b0;
  logic [NbData-1:0] alu_a, alu_b, tx_data;
  logic [NbOp-1:0]   alu_op;
  logic              tx_start, busy, timeout, overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  always #5 clk = ~clk;

  // ALU model: opcode 0x20 is add, everything else yields zero.
  assign alu_result = (alu_op == 6'h20) ? alu_a + alu_b : '0;

  uart_alu_sequencer #(
    .NB_DATA       (NbData),
    .NB_OP         (NbOp),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .i_alu_result(alu_result),
    .i_tx_done   (tx_done),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_op    (alu_op),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_busy      (busy),
    .o_timeout   (timeout),
    .o_overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (tx_start) n_start++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  // Full frame up to WAIT_DONE, checking the result byte and the start pulse timing.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp_res);
    int s0;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    s0 = n_start;
    check({tag, " op latched"}, 32'(alu_op), 32'(op[5:0]));
    check({tag, " no start in exec"}, 32'(tx_start), 32'd0);
    step();
    check({tag, " start"}, 32'(tx_start), 32'd1);
    check({tag, " tx_data"}, 32'(tx_data), 32'(exp_res));
    repeat (4) step();
    check({tag, " one start pulse"}, 32'(n_start - s0), 32'd1);
    check({tag, " busy in wait_done"}, 32'(busy), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int s0;
    logic seen;

    // Reset state
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset outputs", {tx_data, alu_a, alu_b, 2'b00, alu_op},
          32'd0);
    check("reset pulses", {29'd0, tx_start, timeout, overrun}, 32'd0);
    do_reset();

    // 1: add 5 + 3
    run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
    check("alu_a", 32'(alu_a), 32'h05);
    check("alu_b", 32'(alu_b), 32'h03);
    pulse_done();
    check("busy falls after done", 32'(busy), 32'd0);

    // tx_done outside WAIT_DONE is ignored
    pulse_done();
    check("done in idle", 32'(busy), 32'd0);
    send_byte(8'h40);
    pulse_done();
    check("done in wait_b keeps busy", 32'(busy), 32'd1);
    send_byte(8'h02);
    check("wait_b still took B", 32'(alu_b), 32'h02);
    send_byte(8'h20);
    step();
    check("ignored-done frame result", 32'(tx_data), 32'h42);
    step();
    pulse_done();
    check("back to idle", 32'(busy), 32'd0);

    // 2: timeout after silence
    send_byte(8'h11);
    seen = 1'b0;
    repeat (Timeout - 1) begin
      step();
      seen |= timeout;
    end
    check("no early timeout", 32'(seen), 32'd0);
    check("still busy before expiry", 32'(busy), 32'd1);
    step();
    check("timeout pulse", 32'(timeout), 32'd1);
    check("idle after timeout", 32'(busy), 32'd0);
    check("alu_a kept", 32'(alu_a), 32'h11);
    step();
    check("timeout one cycle", 32'(timeout), 32'd0);
    run_frame("post-timeout", 8'h01, 8'h02, 8'h20, 8'h03);

    // 3: overrun during WAIT_DONE
    s0 = n_start;
    send_byte(8'h55);
    check("overrun pulse", 32'(overrun), 32'd1);
    check("overrun keeps busy", 32'(busy), 32'd1);
    check("overrun tx_data", 32'(tx_data), 32'h03);
    check("overrun alu_a", 32'(alu_a), 32'h01);
    step();
    check("overrun one cycle", 32'(overrun), 32'd0);
    check("no extra start", 32'(n_start - s0), 32'd0);
    // Byte together with tx_done: back to IDLE, byte dropped
    rx_data  = 8'h66;
    rx_valid = 1'b1;
    tx_done  = 1'b1;
    step();
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    check("done+byte overrun", 32'(overrun), 32'd1);
    check("done+byte idle", 32'(busy), 32'd0);
    check("done+byte dropped", 32'(alu_a), 32'h01);

    // Byte arriving in the expiry cycle wins
    send_byte(8'h21);
    repeat (Timeout - 1) step();
    send_byte(8'h07);
    check("expiry byte no timeout", 32'(timeout), 32'd0);
    check("expiry byte accepted", 32'(alu_b), 32'h07);
    check("expiry byte busy", 32'(busy), 32'd1);
    seen = 1'b0;
    repeat (Timeout - 1) begin
      step();
      seen |= timeout;
    end
    check("counter restarted", 32'(seen), 32'd0);
    step();
    check("wait_op timeout", 32'(timeout), 32'd1);
    check("wait_op timeout idle", 32'(busy), 32'd0);
    check("wait_op timeout keeps b", 32'(alu_b), 32'h07);
    step();

    // 4: asynchronous reset in WAIT_OP and in SEND
    send_byte(8'h09);
    send_byte(8'h0A);
    #2 rst = 1'b1;
    #1;
    check("async rst wait_op busy", 32'(busy), 32'd0);
    check("async rst wait_op regs", {16'd0, alu_a, alu_b}, 32'd0);
    do_reset();
    s0 = n_start;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    step();
    check("in send", 32'(tx_start), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst send start", 32'(tx_start), 32'd0);
    check("async rst send data", 32'(tx_data), 32'd0);
    check("async rst send busy", 32'(busy), 32'd0);
    do_reset();
    repeat (3) step();
    check("single start across reset", 32'(n_start - s0), 32'd1);

    // 8-bit wrap, opcode truncated from 0xE0, byte during EXEC dropped
    send_byte(8'hFF);
    send_byte(8'h01);
    send_byte(8'hE0);
    check("op truncated", 32'(alu_op), 32'h20);
    send_byte(8'h77);
    check("exec overrun", 32'(overrun), 32'd1);
    check("exec overrun start", 32'(tx_start), 32'd1);
    check("wrap result", 32'(tx_data), 32'h00);
    check("exec overrun alu_a", 32'(alu_a), 32'hFF);
    step();
    pulse_done();
    check("wrap frame idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
